inv_butterfly_32: RTL and testbench

INV_BUTTERFLY_32 -- requirements
Module: inv_butterfly_32

---
 rtl/inv_butterfly_32.sv | 136 +++++++++++++
 tb/tb_inv_butterfly_32.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_butterfly_32.sv
// 32-point inverse butterfly: 16 (even, odd) pairs in, 32 reconstructed samples out in natural order.
// Optional rounding of every output is compiled in with `define INV_BUTTERFLY_ROUND_EN.
module inv_butterfly_32 #(
    parameter int unsigned SHIFT = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [26:0] i_even,
    input  logic [26:0] i_odd,
    output logic        o_valid,
    output logic [27:0] o_data,
    output logic [4:0]  o_idx
);

    localparam int unsigned IN_W  = 27;
    localparam int unsigned DW    = 28;
    localparam int unsigned EW    = 29;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 4;

`ifdef INV_BUTTERFLY_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    // With rounding disabled the offset and shift collapse to zero, leaving x unchanged.
    localparam int unsigned       SHIFT_EFF = ROUND_EN ? SHIFT : 0;
    localparam logic [EW-1:0]     RND       = ROUND_EN ? (EW'(1) << (SHIFT - 1)) : '0;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   k_q, k_d;
    logic [CW-1:0]   j_q, j_d;
    logic            ready_q;
    logic            o_valid_q, o_valid_d;
    logic [DW-1:0]   o_data_q, o_data_d;
    logic [4:0]      o_idx_q, o_idx_d;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   stack_q [DEPTH];

    logic [DW-1:0]   e_x, d_x, s_c, t_c;

    function automatic logic [DW-1:0] fmt(input logic [DW-1:0] x);
        logic signed [EW-1:0] w;
        w = $signed({x[DW-1], x}) + $signed(RND);
        return DW'(w >>> SHIFT_EFF);
    endfunction

    // Sign-extend to 28 bits so neither sum nor difference can wrap.
    always_comb begin
        e_x = {i_even[IN_W-1], i_even};
        d_x = {i_odd[IN_W-1], i_odd};
        s_c = enable ? (e_x + d_x) : e_x;
        t_c = enable ? (e_x - d_x) : d_x;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        j_d       = j_q;
        o_valid_d = 1'b0;
        o_data_d  = o_data_q;
        o_idx_d   = o_idx_q;
        wr_en     = 1'b0;
        wr_data   = fmt(t_c);
        case (state_q)
            FILL: begin
                if (i_valid && ready_q) begin
                    o_valid_d = 1'b1;
                    o_data_d  = fmt(s_c);
                    o_idx_d   = {1'b0, k_q};
                    wr_en     = 1'b1;
                    k_d       = k_q + CW'(1);
                    if (k_q == CW'(DEPTH - 1)) begin
                        state_d = DRAIN;
                        j_d     = '0;
                    end
                end
            end
            DRAIN: begin
                // Pop the difference stack so position 16+j carries t_(15-j).
                o_valid_d = 1'b1;
                o_data_d  = stack_q[CW'(DEPTH - 1) - j_q];
                o_idx_d   = {1'b1, j_q};
                j_d       = j_q + CW'(1);
                if (j_q == CW'(DEPTH - 1)) begin
                    state_d = FILL;
                    k_d     = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            k_q       <= '0;
            j_q       <= '0;
            ready_q   <= 1'b1;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            j_q       <= j_d;
            ready_q   <= (state_d == FILL);
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_idx_q   <= o_idx_d;
        end
    end

    // Difference stack: never read before written within a block, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[k_q] <= wr_data;
        end
    end

    assign i_ready = ready_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_idx   = o_idx_q;

endmodule

// File: tb/tb_inv_butterfly_32.sv
// Scoreboard bench for inv_butterfly_32: driver predicts outputs from the butterfly rules, monitor compares.
module tb_inv_butterfly_32;

    localparam int SHIFT = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [26:0] i_even = '0;
    logic [26:0] i_odd = '0;
    logic        o_valid;
    logic [27:0] o_data;
    logic [4:0]  o_idx;

    always #5 clk = ~clk;

    inv_butterfly_32 #(.SHIFT(SHIFT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_even  (i_even),
        .i_odd   (i_odd),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_idx   (o_idx)
    );

    typedef struct {
        int     idx;
        longint val;
    } exp_t;

    exp_t   sbq[$];
    int     n_tests = 0;
    int     n_fail = 0;
    longint tstk[16];
    int     mk = 0;
    int     drain_left = 0;
    longint last_val = 0;
    int     last_idx = 0;
    bit     prev_valid = 1'b0;
    bit     mon_en = 1'b0;

    // Output value rule: identity, or round-half-up then floor-divide by 2^SHIFT.
    function automatic longint fmt(input longint x);
`ifdef INV_BUTTERFLY_ROUND_EN
        longint y, p;
        p = longint'(1) << SHIFT;
        y = x + p / 2;
        if (y >= 0) return y / p;
        return -((-y + p - 1) / p);
`else
        return x;
`endif
    endfunction

    function automatic void push(input int idx, input longint val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        sbq.push_back(e);
    endfunction

    task automatic step(input bit v, input bit en, input longint e, input longint d);
        bit     exp_ready;
        longint s, t;
        @(negedge clk);
        exp_ready = (drain_left == 0);
        n_tests++;
        if (i_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL i_ready: got %b want %b at %0t", i_ready, exp_ready, $time);
        end
        i_valid = v;
        enable  = en;
        i_even  = 27'(e);
        i_odd   = 27'(d);
        if (!exp_ready) begin
            drain_left--;
        end else if (v) begin
            s = en ? e + d : e;
            t = en ? e - d : d;
            push(mk, fmt(s));
            tstk[mk] = fmt(t);
            mk++;
            if (mk == 16) begin
                for (int p = 16; p < 32; p++) push(p, tstk[31 - p]);
                mk = 0;
                drain_left = 16;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        sbq.delete();
        mk = 0;
        drain_left = 0;
        last_val = 0;
        last_idx = 0;
        prev_valid = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || o_data !== 28'd0 || o_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%h i=%0d want 0/0/0", o_valid, o_data, o_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic longint rnd27();
        logic [26:0] r;
        r = 27'($urandom);
        return longint'($signed(r));
    endfunction

    // Monitor: pops the scoreboard on every valid beat, checks hold values otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got idx=%0d data=%0d want none", o_idx, $signed(o_data));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    n_tests++;
                    if (o_idx !== 5'(e.idx) || longint'($signed(o_data)) != e.val) begin
                        n_fail++;
                        $display("FAIL out_beat: got idx=%0d data=%0d want idx=%0d data=%0d",
                                 o_idx, $signed(o_data), e.idx, e.val);
                    end
                    if (e.idx >= 16) begin
                        n_tests++;
                        if (!prev_valid) begin
                            n_fail++;
                            $display("FAIL drain_contig: got gap before idx=%0d want contiguous", e.idx);
                        end
                    end
                    last_val = e.val;
                    last_idx = e.idx;
                end
            end else begin
                n_tests++;
                if (o_valid !== 1'b0 || longint'($signed(o_data)) != last_val || o_idx !== 5'(last_idx)) begin
                    n_fail++;
                    $display("FAIL hold: got v=%b data=%0d idx=%0d want v=0 data=%0d idx=%0d",
                             o_valid, $signed(o_data), o_idx, last_val, last_idx);
                end
            end
            prev_valid = (o_valid === 1'b1);
        end
    end

    initial begin
        int acc;
        bit pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        do_reset();
        mon_en = 1'b1;

        // Ramp even part against constant odd part, back to back, input held valid in drain.
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, longint'(k + 1), 100);
        for (int j = 0; j < 16; j++) step(1'b1, 1'b1, 999, -999);

        // Pass-through.
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, -5, 7);
        for (int j = 0; j < 16; j++) step(1'b0, 1'b0, 0, 0);

        // Extremes.
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) step(1'b1, 1'b1, (longint'(1) << 26) - 1, (longint'(1) << 26) - 1);
            else            step(1'b1, 1'b1, -(longint'(1) << 26), (longint'(1) << 26) - 1);
        end
        for (int j = 0; j < 16; j++) step(1'b0, 1'b1, 0, 0);

        // Input gaps 1,0,0,1 during fill.
        acc = 0;
        for (int c = 0; acc < 16; c++) begin
            step(pat[c % 4], 1'b1, rnd27(), rnd27());
            if (pat[c % 4]) acc++;
        end
        for (int j = 0; j < 16; j++) step(1'b0, 1'b1, 0, 0);

        // Reset at drain j=5 abandons the rest of the block.
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, rnd27(), rnd27());
        for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 0, 0);
        do_reset();

        // Reset partway through fill.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, rnd27(), rnd27());
        do_reset();

        // Random traffic, inputs toggling also during drain.
        for (int c = 0; c < 700; c++)
            step(($urandom_range(0, 3) != 0), 1'($urandom), rnd27(), rnd27());
        for (int c = 0; c < 40; c++) step(1'b0, 1'b0, 0, 0);

        @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending beats want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
